// File: rtl/fcvt_arbiter_if.sv
// Bundle of requester, converter and response signals for fcvt_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface fcvt_arbiter_if #(
   parameter int TAG_W = 4
);
   logic             flush_i;
   logic             req0_valid_i, req1_valid_i;
   logic             req0_ready_o, req1_ready_o;
   logic [31:0]      req0_src_i, req1_src_i;
   logic [2:0]       req0_rm_i, req1_rm_i;
   logic [TAG_W-1:0] req0_tag_i, req1_tag_i;
   logic [2:0]       frm_i;
   logic [31:0]      cvt_src_o;
   logic [2:0]       cvt_rm_o;
   logic [31:0]      cvt_result_i;
   logic             rsp_valid_o;
   logic             rsp_ready_i;
   logic [31:0]      rsp_result_o;
   logic [TAG_W-1:0] rsp_tag_o;
   logic             rsp_id_o;
   logic [4:0]       rsp_fflags_o;
   logic             rsp_illegal_o;

   modport slave (
      input  flush_i, req0_valid_i, req1_valid_i, req0_src_i, req1_src_i,
             req0_rm_i, req1_rm_i, req0_tag_i, req1_tag_i, frm_i,
             cvt_result_i, rsp_ready_i,
      output req0_ready_o, req1_ready_o, cvt_src_o, cvt_rm_o, rsp_valid_o,
             rsp_result_o, rsp_tag_o, rsp_id_o, rsp_fflags_o, rsp_illegal_o
   );

   modport master (
      output flush_i, req0_valid_i, req1_valid_i, req0_src_i, req1_src_i,
             req0_rm_i, req1_rm_i, req0_tag_i, req1_tag_i, frm_i,
             cvt_result_i, rsp_ready_i,
      input  req0_ready_o, req1_ready_o, cvt_src_o, cvt_rm_o, rsp_valid_o,
             rsp_result_o, rsp_tag_o, rsp_id_o, rsp_fflags_o, rsp_illegal_o
   );
endinterface

// File: rtl/fcvt_arbiter.sv
// Two-requester round-robin front end for an FCVT.W.S converter (IDLE/CVT/RSP).
// Define FCVT_ARB_FFLAGS_EN to compute NV/NX; otherwise rsp_fflags_o is zero.
module fcvt_arbiter #(
   parameter int TAG_W = 4
) (
   input logic          clk,
   input logic          reset_n,
   fcvt_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CVT, RSP} state_t;

   state_t           state;
   logic             last_id;
   logic [31:0]      src_q;
   logic [2:0]       rm_q;
   logic [TAG_W-1:0] tag_q;
   logic             id_q;
   logic [31:0]      result_q;
   logic [4:0]       fflags_q;
   logic             illegal_q;
   logic             rsp_valid_q;

   logic gnt0, gnt1, idle_ok, acc0, acc1, accept, rm_ill;
   logic [2:0] req_rm, res_rm;
   logic [4:0] flags_d;

   // On a tie the requester that was not accepted last wins.
   assign gnt0    = bus.req0_valid_i & (~bus.req1_valid_i | last_id);
   assign gnt1    = bus.req1_valid_i & (~bus.req0_valid_i | ~last_id);
   assign idle_ok = reset_n & (state == IDLE) & ~bus.flush_i;
   assign acc0    = idle_ok & gnt0;
   assign acc1    = idle_ok & gnt1;
   assign accept  = acc0 | acc1;
   assign req_rm  = acc1 ? bus.req1_rm_i : bus.req0_rm_i;
   assign res_rm  = (req_rm == 3'b111) ? bus.frm_i : req_rm;
   assign rm_ill  = rm_q[2] & (rm_q[1] | rm_q[0]);

   assign bus.req0_ready_o  = acc0;
   assign bus.req1_ready_o  = acc1;
   assign bus.cvt_src_o     = src_q;
   assign bus.cvt_rm_o      = rm_q;
   assign bus.rsp_valid_o   = rsp_valid_q;
   assign bus.rsp_result_o  = result_q;
   assign bus.rsp_tag_o     = tag_q;
   assign bus.rsp_id_o      = id_q;
   assign bus.rsp_fflags_o  = fflags_q;
   assign bus.rsp_illegal_o = illegal_q;

`ifdef FCVT_ARB_FFLAGS_EN
   logic [7:0]  exp_f;
   logic [23:0] frac_mask;
   logic        nv_f, nx_f;

   // frac_mask selects the mantissa bits that lie below the binary point.
   always_comb begin
      exp_f     = src_q[30:23];
      frac_mask = '0;
      if (exp_f >= 8'd127 && exp_f < 8'd150)
         frac_mask = (24'd1 << (8'd150 - exp_f)) - 24'd1;
      nv_f    = (exp_f == 8'hFF) | ((exp_f >= 8'd158) & (src_q != 32'hCF00_0000));
      nx_f    = ~nv_f & (((exp_f < 8'd127) & (src_q[30:0] != 31'd0)) |
                         ((frac_mask & {1'b0, src_q[22:0]}) != 24'd0));
      flags_d = {nv_f, 3'b000, nx_f};
   end
`else
   assign flags_d = 5'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         last_id     <= 1'b1;
         src_q       <= '0;
         rm_q        <= '0;
         tag_q       <= '0;
         id_q        <= 1'b0;
         result_q    <= '0;
         fflags_q    <= '0;
         illegal_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else if (bus.flush_i) begin
         state       <= IDLE;
         rsp_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               src_q   <= acc1 ? bus.req1_src_i : bus.req0_src_i;
               tag_q   <= acc1 ? bus.req1_tag_i : bus.req0_tag_i;
               id_q    <= acc1;
               rm_q    <= res_rm;
               last_id <= acc1;
               state   <= CVT;
            end
            CVT: begin
               result_q    <= rm_ill ? 32'd0 : bus.cvt_result_i;
               fflags_q    <= rm_ill ? 5'd0 : flags_d;
               illegal_q   <= rm_ill;
               rsp_valid_q <= 1'b1;
               state       <= RSP;
            end
            RSP: if (bus.rsp_ready_i) begin
               rsp_valid_q <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fcvt_arbiter.sv
// Scoreboard bench for fcvt_arbiter: per-requester op queues feed the DUT,
// accepts push expected responses, a negedge monitor compares what comes out.
module tb_fcvt_arbiter;
   localparam int TAG_W = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   fcvt_arbiter_if #(.TAG_W(TAG_W)) bus ();
   fcvt_arbiter #(.TAG_W(TAG_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] src; logic [2:0] rm; logic [TAG_W-1:0] tag;
      logic [31:0] res; logic [4:0] fl; logic ill;
   } op_t;
   typedef struct {
      logic [31:0] res; logic [TAG_W-1:0] tag; logic id;
      logic [4:0] fl; logic ill; int acc;
   } exp_t;

   op_t  q0[$], q1[$];
   exp_t sb[$];
   int   grant_log[$];
   int   tests = 0, fails = 0, cyc = 0, first_seen = 0;
   logic prev_valid = 1'b0;

   function automatic logic [4:0] xf(input logic [4:0] f);
`ifdef FCVT_ARB_FFLAGS_EN
      return f;
`else
      return 5'b0 & f;
`endif
   endfunction

   function automatic op_t mk(input logic [31:0] src, input logic [2:0] rm,
                              input logic [TAG_W-1:0] tag, input logic [31:0] res,
                              input logic [4:0] fl, input logic ill);
      op_t o;
      o.src = src; o.rm = rm; o.tag = tag; o.res = res; o.fl = fl; o.ill = ill;
      return o;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Converter stand-in: hand-computed FCVT.W.S results for the operands used.
   always_comb begin
      case (bus.cvt_src_o)
         32'h3F80_0000: bus.cvt_result_i = 32'd1;
         32'h4000_0000: bus.cvt_result_i = 32'd2;
         32'h4040_0000: bus.cvt_result_i = 32'd3;
         32'h4080_0000: bus.cvt_result_i = 32'd4;
         32'h4049_0FDB: bus.cvt_result_i = 32'd3;
         32'h7FC0_0000: bus.cvt_result_i = 32'h7FFF_FFFF;
         32'hCF00_0000: bus.cvt_result_i = 32'h8000_0000;
         32'h3F00_0000: bus.cvt_result_i = 32'd0;
         32'hBFC0_0000: bus.cvt_result_i = 32'hFFFF_FFFE;
         default:       bus.cvt_result_i = 32'hDEAD_BEEF;
      endcase
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Requester drivers: present the head of each queue, updated after each edge.
   initial begin
      bus.req0_valid_i = 0; bus.req0_src_i = 0; bus.req0_rm_i = 0; bus.req0_tag_i = 0;
      bus.req1_valid_i = 0; bus.req1_src_i = 0; bus.req1_rm_i = 0; bus.req1_tag_i = 0;
      forever begin
         @(posedge clk); #1;
         bus.req0_valid_i = (q0.size() > 0);
         if (q0.size() > 0) begin
            bus.req0_src_i = q0[0].src; bus.req0_rm_i = q0[0].rm; bus.req0_tag_i = q0[0].tag;
         end
         bus.req1_valid_i = (q1.size() > 0);
         if (q1.size() > 0) begin
            bus.req1_src_i = q1[0].src; bus.req1_rm_i = q1[0].rm; bus.req1_tag_i = q1[0].tag;
         end
      end
   end

   // Accept detector: an accepted op becomes an expected response.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (reset_n && bus.req0_ready_o && bus.req1_ready_o) begin
         tests++; fails++;
         $display("FAIL dual_ready: got both readies high, expected at most one");
      end
      if (reset_n && bus.req0_valid_i && bus.req0_ready_o && q0.size() > 0) begin
         e.res = q0[0].res; e.tag = q0[0].tag; e.id = 1'b0; e.fl = q0[0].fl;
         e.ill = q0[0].ill; e.acc = cyc;
         sb.push_back(e); grant_log.push_back(0); void'(q0.pop_front());
      end
      if (reset_n && bus.req1_valid_i && bus.req1_ready_o && q1.size() > 0) begin
         e.res = q1[0].res; e.tag = q1[0].tag; e.id = 1'b1; e.fl = q1[0].fl;
         e.ill = q1[0].ill; e.acc = cyc;
         sb.push_back(e); grant_log.push_back(1); void'(q1.pop_front());
      end
   end

   // Monitor: every cycle rsp_valid_o is high the outputs must equal the head entry.
   initial forever begin
      @(negedge clk);
      if (!reset_n) prev_valid = 1'b0;
      else begin
         if (bus.rsp_valid_o) begin
            if (!prev_valid) first_seen = cyc;
            if (sb.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_rsp: got rsp_valid_o=1 tag=0x%0h, expected no response",
                        bus.rsp_tag_o);
            end else begin
               check("rsp_result", bus.rsp_result_o, sb[0].res);
               check("rsp_tag", {{(32-TAG_W){1'b0}}, bus.rsp_tag_o}, {{(32-TAG_W){1'b0}}, sb[0].tag});
               check("rsp_id", {31'd0, bus.rsp_id_o}, {31'd0, sb[0].id});
               check("rsp_fflags", {27'd0, bus.rsp_fflags_o}, {27'd0, sb[0].fl});
               check("rsp_illegal", {31'd0, bus.rsp_illegal_o}, {31'd0, sb[0].ill});
               if (!prev_valid) check("latency", first_seen - sb[0].acc, 32'd2);
               if (bus.rsp_ready_i && !bus.flush_i) void'(sb.pop_front());
            end
         end
         prev_valid = bus.rsp_valid_o;
      end
   end

   task automatic drain(input string name);
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && n < 100) begin
         @(negedge clk); n++;
      end
      tests++;
      if (n >= 100) begin
         fails++;
         $display("FAIL %s_timeout: got %0d pending ops after 100 cycles, expected 0",
                  name, q0.size() + q1.size() + sb.size());
         q0.delete(); q1.delete(); sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_accept(input string name);
      int g = grant_log.size();
      int n = 0;
      while (grant_log.size() == g && n < 20) begin
         @(negedge clk); #1; n++;
      end
      tests++;
      if (grant_log.size() == g) begin
         fails++;
         $display("FAIL %s_accept_timeout: got no accept in 20 cycles, expected one", name);
      end
   endtask

   initial begin
      int exp_gnt[4];
      exp_gnt = '{0, 1, 0, 1};
      bus.flush_i = 0; bus.rsp_ready_i = 1; bus.frm_i = 3'b000;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
      check("rst_cvt_src", bus.cvt_src_o, 32'd0);
      check("rst_cvt_rm", {29'd0, bus.cvt_rm_o}, 32'd0);
      check("rst_rsp_result", bus.rsp_result_o, 32'd0);
      check("rst_rsp_id_tag", {27'd0, bus.rsp_id_o, bus.rsp_tag_o}, 32'd0);
      check("rst_fflags_ill", {26'd0, bus.rsp_fflags_o, bus.rsp_illegal_o}, 32'd0);
      @(posedge clk); #2; reset_n = 1;

      // round robin on constant ties: requester 0 first after reset
      q0.push_back(mk(32'h3F80_0000, 3'b000, 4'd1, 32'd1, 5'b0, 1'b0));
      q0.push_back(mk(32'h4040_0000, 3'b000, 4'd3, 32'd3, 5'b0, 1'b0));
      q1.push_back(mk(32'h4000_0000, 3'b000, 4'd2, 32'd2, 5'b0, 1'b0));
      q1.push_back(mk(32'h4080_0000, 3'b000, 4'd4, 32'd4, 5'b0, 1'b0));
      drain("rr");
      check("rr_grant_count", grant_log.size(), 32'd4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         check($sformatf("rr_grant%0d", i), grant_log[i], exp_gnt[i]);

      // single-op conversions with flags
      q0.push_back(mk(32'h4049_0FDB, 3'b000, 4'hA, 32'd3, xf(5'b00001), 1'b0));
      drain("pi");
      q1.push_back(mk(32'h7FC0_0000, 3'b001, 4'hB, 32'h7FFF_FFFF, xf(5'b10000), 1'b0));
      drain("nan");
      q0.push_back(mk(32'hCF00_0000, 3'b001, 4'hC, 32'h8000_0000, 5'b0, 1'b0));
      drain("min_int");
      q1.push_back(mk(32'h3F00_0000, 3'b000, 4'hD, 32'd0, xf(5'b00001), 1'b0));
      drain("half");

      // dynamic rounding mode, legal then illegal frm
      @(posedge clk); #2; bus.frm_i = 3'b010;
      q0.push_back(mk(32'hBFC0_0000, 3'b111, 4'hE, 32'hFFFF_FFFE, xf(5'b00001), 1'b0));
      drain("dyn_rdn");
      @(posedge clk); #2; bus.frm_i = 3'b101;
      q0.push_back(mk(32'hBFC0_0000, 3'b111, 4'hF, 32'd0, 5'b0, 1'b1));
      drain("dyn_ill");
      @(posedge clk); #2; bus.frm_i = 3'b000;
      q1.push_back(mk(32'h4000_0000, 3'b110, 4'h3, 32'd0, 5'b0, 1'b1));
      drain("static_ill");

      // back-pressure: response held 5 cycles, no accepts meanwhile
      @(posedge clk); #2; bus.rsp_ready_i = 0;
      q0.push_back(mk(32'h3F80_0000, 3'b000, 4'd5, 32'd1, 5'b0, 1'b0));
      wait_accept("stall");
      q1.push_back(mk(32'h4000_0000, 3'b000, 4'd6, 32'd2, 5'b0, 1'b0));
      @(posedge clk); #2;
      @(posedge clk); #2;
      repeat (5) begin
         @(negedge clk);
         check("stall_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
         check("stall_readies", {30'd0, bus.req0_ready_o, bus.req1_ready_o}, 32'd0);
      end
      @(posedge clk); #2; bus.rsp_ready_i = 1;
      drain("stall");

      // flush during CVT: op dropped, waiting requester accepted right after
      q0.push_back(mk(32'h4040_0000, 3'b000, 4'd7, 32'd3, 5'b0, 1'b0));
      wait_accept("flush_cvt");
      q1.push_back(mk(32'h4080_0000, 3'b000, 4'd8, 32'd4, 5'b0, 1'b0));
      @(posedge clk); #2; bus.flush_i = 1;
      @(negedge clk);
      check("flush_readies", {30'd0, bus.req0_ready_o, bus.req1_ready_o}, 32'd0);
      @(posedge clk); #2; bus.flush_i = 0; sb.delete();
      @(negedge clk);
      check("flush_next_accept", {30'd0, bus.req0_ready_o, bus.req1_ready_o}, 32'd1);
      drain("flush_cvt");

      // flush coincident with rsp_ready in RSP: response not delivered
      q0.push_back(mk(32'h3F80_0000, 3'b000, 4'd9, 32'd1, 5'b0, 1'b0));
      wait_accept("flush_rsp");
      q1.push_back(mk(32'h4000_0000, 3'b000, 4'hA, 32'd2, 5'b0, 1'b0));
      @(posedge clk); #2;
      @(posedge clk); #2; bus.flush_i = 1;
      @(negedge clk);
      check("flush_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
      check("flush_rsp_readies", {30'd0, bus.req0_ready_o, bus.req1_ready_o}, 32'd0);
      @(posedge clk); #2; bus.flush_i = 0; sb.delete();
      @(negedge clk);
      check("flush_rsp_dropped", {31'd0, bus.rsp_valid_o}, 32'd0);
      check("flush_rsp_next", {30'd0, bus.req0_ready_o, bus.req1_ready_o}, 32'd1);
      drain("flush_rsp");

      // reset mid-operation: nothing emitted afterwards
      q0.push_back(mk(32'h4000_0000, 3'b000, 4'hB, 32'd2, 5'b0, 1'b0));
      wait_accept("reset_mid");
      @(posedge clk); #2; reset_n = 0; sb.delete();
      @(negedge clk);
      check("rst_mid_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
      check("rst_mid_cvt_src", bus.cvt_src_o, 32'd0);
      @(posedge clk); #2; reset_n = 1;
      repeat (6) @(negedge clk);
      check("final_sb_empty", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fcvt_arbiter.md
FCVT_ARBITER -- requirements
Module: fcvt_arbiter

Interface
REQ-001 Parameter TAG_W, default 4, width of requester tag carried through to response.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 flush_i  input  1  kills any in-flight or pending conversion.
REQ-005 reqN_valid_i  input  1  (N=0,1) requester N presents an FCVT.W.S operation.
REQ-006 reqN_ready_o  output  1  (N=0,1) arbiter accepts requester N this cycle.
REQ-007 reqN_src_i  input  32  (N=0,1) IEEE-754 single operand.
REQ-008 reqN_rm_i  input  3  (N=0,1) instruction rm field; 3'b111 = dynamic.
REQ-009 reqN_tag_i  input  TAG_W  (N=0,1) opaque tag returned with result.
REQ-010 frm_i  input  3  CSR frm, used when resolved rm is dynamic.
REQ-011 cvt_src_o  output  32  operand to float-to-int converter.
REQ-012 cvt_rm_o  output  3  resolved static rounding mode to converter.
REQ-013 cvt_result_i  input  32  combinational converter result.
REQ-014 rsp_valid_o / rsp_ready_i  output / input  1 / 1  response handshake.
REQ-015 rsp_result_o  output  32  signed integer result.
REQ-016 rsp_tag_o  output  TAG_W; rsp_id_o  output  1  source requester index.
REQ-017 rsp_fflags_o  output  5  {NV,DZ,OF,UF,NX}; rsp_illegal_o  output  1  illegal rounding mode.

Function
REQ-018 FSM states IDLE, CVT, RSP; IDLE->CVT on accept, CVT->RSP unconditionally, RSP->IDLE when rsp_ready_i=1.
REQ-019 reqN_ready_o=1 only in IDLE, flush_i=0, and N granted; at most one ready high per cycle.
REQ-020 Grant: single valid requester wins; both valid -> requester other than last-accepted wins (round-robin pointer updates only on accept).
REQ-021 Accept (valid&ready) latches src, tag, id, resolved rm (rm_i, or frm_i sampled that cycle when rm_i=3'b111).
REQ-022 cvt_src_o/cvt_rm_o driven from latched registers; cvt_result_i captured at end of CVT.
REQ-023 Latency: accept at edge N -> rsp_valid_o high in cycle N+2; peak throughput one op per 3 cycles.
REQ-024 Resolved rm in {3'b101,3'b110,3'b111}: rsp_result_o=0, rsp_fflags_o=0, rsp_illegal_o=1.
REQ-025 NV=1 when exp=255, or exp>=158, except operand exactly 0xCF000000 (-2^31, NV=0).
REQ-026 NX=1 when NV=0 and fraction nonzero: exp<127 with operand magnitude nonzero, or 127<=exp<150 with mantissa bits [149-exp:0] nonzero; DZ, OF, UF always 0.
REQ-027 All rsp_* outputs stable while rsp_valid_o=1 and rsp_ready_i=0; no new accept during CVT/RSP.
REQ-028 flush_i=1 in any state: next state IDLE, rsp_valid_o=0 next cycle, readies low that cycle, round-robin pointer unchanged.
REQ-029 flush_i coincident with rsp_ready_i in RSP: response counts as not delivered; no accept that cycle.

Reset
REQ-030 reset_n low: state IDLE, all outputs 0, latched registers 0, round-robin pointer = 1 (requester 0 wins first tie).
REQ-031 Reset assertion mid-operation discards the operation immediately; no response emitted after release.

Configuration
REQ-032 Macro FCVT_ARB_FFLAGS_EN defined: rsp_fflags_o computed per REQ-025/026.
REQ-033 FCVT_ARB_FFLAGS_EN undefined: rsp_fflags_o tied to 5'b0, flag logic absent; all other behaviour identical.

Verification
REQ-034 req0 src=0x40490FDB (3.14159), rm=000 -> rsp_result_o=3, fflags=5'b00001, rsp_valid_o at accept+2.
REQ-035 req0 and req1 valid together, repeated 4 ops -> grants 0,1,0,1; rsp_id_o matches, tags preserved.
REQ-036 src=0x7FC00000 (NaN), rm=001 -> rsp_result_o=0x7FFFFFFF, NV=1; src=0xCF000000 -> 0x80000000, fflags=0.
REQ-037 rm=111, frm_i=010, src=0xBFC00000 (-1.5) -> result 0xFFFFFFFE; frm_i=101 -> rsp_illegal_o=1, result 0.
REQ-038 rsp_ready_i held low 5 cycles -> outputs stable, reqN_ready_o low; flush_i in CVT -> no response, next accept at flush+1.
